bnn_window_reader: RTL and testbench

Read-side controller for the 1-bit BNN line buffers. It accepts a raster stream of binary pixels and drives the rd/wr strobes of two 14-bit line buffers, lb0 (row y-2) and lb1 (row y-1). It captures their registered data_out and assembles a 3x3 binary window for the XNOR-popcount stage. It owns all line-buffer sequencing, including per-frame flush, so the buffers never see simultaneous rd and wr.

---
 rtl/bnn_window_reader.sv | 243 ++++++++++++++++++++++++
 tb/tb_bnn_window_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_window_reader.sv
// ---------------------------------------------------------------------------
// bnn_window_reader
//
// Read-side controller for the two 1-bit BNN line buffers. It takes a raster
// stream of binary pixels, one at a time, and sequences the line buffers:
//   lb1 holds row y-1 and lb0 holds row y-2.
// Each pixel is processed in four cycles: IDLE, RD, CAP and WR.
//   - IDLE accepts the pixel.
//   - RD pops the buffers.
//   - CAP captures their registered data.
//   - WR pushes the new pixel into lb1 and the popped lb1 bit into lb0, then
//     shifts the 3x3 window.
// After the last pixel of a frame, one FLUSH cycle clears both buffers and
// pulses frame_done. A buffer is never read and written in the same cycle.
//
// Parameters
//   IMG_W       pixels per row (must equal the line-buffer depth)
//   IMG_H       rows per frame
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   pix_valid   pixel offered (only looked at in IDLE)
//   pix_in      binary pixel (sampled only in IDLE)
//   pix_ready   high while in IDLE
//   lb0_rd      read strobe, row y-2 buffer
//   lb1_rd      read strobe, row y-1 buffer
//   lb0_wr      write strobe, row y-2 buffer
//   lb1_wr      write strobe, row y-1 buffer
//   lb0_din     write data, row y-2 buffer
//   lb1_din     write data, row y-1 buffer
//   lb0_data    registered line-buffer output, valid the cycle after rd
//   lb1_data    registered line-buffer output, valid the cycle after rd
//   lb0_empty   line-buffer empty flag
//   lb1_empty   line-buffer empty flag
//   lb_rst      one-cycle synchronous clear for both buffers
//   win         3x3 window {r0,r1,r2}; win[8]=(x-2,y-2), win[0]=(x,y)
//   win_valid   one-cycle pulse when win holds a complete window
//   frame_done  one-cycle pulse after the last pixel of a frame
//   err         sticky underflow flag (cleared only by rst)
// ---------------------------------------------------------------------------
module bnn_window_reader #(
  parameter int IMG_W = 14,
  parameter int IMG_H = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic       pix_in,
  output logic       pix_ready,
  output logic       lb0_rd,
  output logic       lb1_rd,
  output logic       lb0_wr,
  output logic       lb1_wr,
  output logic       lb0_din,
  output logic       lb1_din,
  input  logic       lb0_data,
  input  logic       lb1_data,
  input  logic       lb0_empty,
  input  logic       lb1_empty,
  output logic       lb_rst,
  output logic [8:0] win,
  output logic       win_valid,
  output logic       frame_done,
  output logic       err
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_pixQ;
  logic               r_b0;
  logic               r_b1;
  logic               r_rd0Ok;
  logic               r_rd1Ok;
  logic [2:0]         r_r0;
  logic [2:0]         r_r1;
  logic [2:0]         r_r2;
  logic [8:0]         r_win;
  logic               r_winValid;
  logic               r_err;

  logic               w_row1;
  logic               w_row2;
  logic               w_col2;
  logic               w_lastCol;
  logic               w_lastRow;
  logic               w_lastPix;
  logic               w_need0;
  logic               w_need1;

  // Row/column qualifiers. A row >= 1 means lb1 holds the previous row.
  // A row >= 2 means lb0 holds the row before that. A column >= 2 means the
  // shift registers hold three columns of the current rows.
  assign w_row1    = (r_row >= ROW_W'(1));
  assign w_row2    = (r_row >= ROW_W'(2));
  assign w_col2    = (r_col >= COL_W'(2));
  assign w_lastCol = (r_col == COL_W'(IMG_W - 1));
  assign w_lastRow = (r_row == ROW_W'(IMG_H - 1));
  assign w_lastPix = w_lastCol && w_lastRow;

  // A read is only issued when it is required and the buffer has data.
  // A required read against an empty buffer is an underflow.
  assign w_need1 = w_row1;
  assign w_need0 = w_row2;

  assign win       = r_win;
  assign win_valid = r_winValid;
  assign err       = r_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and the strobes driven straight from the state.
  // Reads happen only in RD and writes only in WR, so a buffer never sees
  // rd and wr together.
  always_comb begin
    w_nextState = r_state;
    pix_ready   = 1'b0;
    lb0_rd      = 1'b0;
    lb1_rd      = 1'b0;
    lb0_wr      = 1'b0;
    lb1_wr      = 1'b0;
    lb0_din     = 1'b0;
    lb1_din     = 1'b0;
    lb_rst      = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          w_nextState = ST_RD;
        end
      end
      ST_RD: begin
        lb1_rd      = w_need1 && !lb1_empty;
        lb0_rd      = w_need0 && !lb0_empty;
        w_nextState = ST_CAP;
      end
      ST_CAP: begin
        w_nextState = ST_WR;
      end
      ST_WR: begin
        lb1_wr      = 1'b1;
        lb1_din     = r_pixQ;
        lb0_wr      = w_row1;
        lb0_din     = w_row1 && r_b1;
        w_nextState = w_lastPix ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        lb_rst      = 1'b1;
        frame_done  = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Datapath for each pixel:
  //   - Latch the pixel on accept.
  //   - Remember which reads actually went out.
  //   - Capture the buffer outputs one cycle later.
  //   - In WR, shift the window rows and advance the raster counters.
  // The shift registers are deliberately not cleared at row start. Their
  // stale bits are masked because win_valid requires col >= 2. win only
  // updates on a valid window, so it holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pixQ     <= 1'b0;
      r_b0       <= 1'b0;
      r_b1       <= 1'b0;
      r_rd0Ok    <= 1'b0;
      r_rd1Ok    <= 1'b0;
      r_r0       <= '0;
      r_r1       <= '0;
      r_r2       <= '0;
      r_win      <= '0;
      r_winValid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_winValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (pix_valid) begin
            r_pixQ <= pix_in;
          end
        end
        ST_RD: begin
          r_rd1Ok <= w_need1 && !lb1_empty;
          r_rd0Ok <= w_need0 && !lb0_empty;
          if ((w_need1 && lb1_empty) || (w_need0 && lb0_empty)) begin
            r_err <= 1'b1;
          end
        end
        ST_CAP: begin
          r_b1 <= r_rd1Ok && lb1_data;
          r_b0 <= r_rd0Ok && lb0_data;
        end
        ST_WR: begin
          r_r2       <= {r_r2[1:0], r_pixQ};
          r_r1       <= {r_r1[1:0], r_b1};
          r_r0       <= {r_r0[1:0], r_b0};
          r_winValid <= w_row2 && w_col2;
          if (w_row2 && w_col2) begin
            r_win <= {r_r0[1:0], r_b0, r_r1[1:0], r_b1, r_r2[1:0], r_pixQ};
          end
          if (w_lastCol) begin
            r_col <= '0;
            r_row <= w_lastRow ? '0 : r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_window_reader.sv
// ---------------------------------------------------------------------------
// tb_bnn_window_reader
//
// Directed bench for bnn_window_reader. It contains behavioural models of the
// two line buffers: depth IMG_W, registered data_out, an empty flag and a
// synchronous clear. Expected windows are rebuilt from the pixel pattern
// functions below.
// ---------------------------------------------------------------------------
module tb_bnn_window_reader;

  localparam int W = 14;
  localparam int H = 14;

  logic       clk;
  logic       rst;
  logic       pix_valid;
  logic       pix_in;
  logic       pix_ready;
  logic       lb0_rd, lb1_rd, lb0_wr, lb1_wr, lb0_din, lb1_din;
  logic       lb0_data, lb1_data, lb0_empty, lb1_empty;
  logic       lb_rst;
  logic [8:0] win;
  logic       win_valid;
  logic       frame_done;
  logic       err;

  int checks = 0;
  int errors = 0;

  bnn_window_reader #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
    .lb0_rd(lb0_rd), .lb1_rd(lb1_rd), .lb0_wr(lb0_wr), .lb1_wr(lb1_wr),
    .lb0_din(lb0_din), .lb1_din(lb1_din),
    .lb0_data(lb0_data), .lb1_data(lb1_data),
    .lb0_empty(lb0_empty), .lb1_empty(lb1_empty),
    .lb_rst(lb_rst), .win(win), .win_valid(win_valid),
    .frame_done(frame_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural line buffers. The top level clears them on rst as well as
  // on lb_rst. force1 lets a directed step fake an empty lb1.
  logic mem0 [0:W-1];
  logic mem1 [0:W-1];
  int   wp0, rp0, cnt0, wp1, rp1, cnt1;
  logic force1;
  logic conflict;
  logic overflow;

  assign lb0_empty = (cnt0 == 0);
  assign lb1_empty = force1 || (cnt1 == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wp0 <= 0; rp0 <= 0; cnt0 <= 0;
      wp1 <= 0; rp1 <= 0; cnt1 <= 0;
      lb0_data <= 1'b0; lb1_data <= 1'b0;
      conflict <= 1'b0; overflow <= 1'b0;
    end else if (lb_rst) begin
      wp0 <= 0; rp0 <= 0; cnt0 <= 0;
      wp1 <= 0; rp1 <= 0; cnt1 <= 0;
    end else begin
      if (lb0_rd) begin lb0_data <= mem0[rp0]; rp0 <= (rp0 + 1) % W; end
      if (lb1_rd) begin lb1_data <= mem1[rp1]; rp1 <= (rp1 + 1) % W; end
      if (lb0_wr) begin mem0[wp0] <= lb0_din; wp0 <= (wp0 + 1) % W; end
      if (lb1_wr) begin mem1[wp1] <= lb1_din; wp1 <= (wp1 + 1) % W; end
      cnt0 <= cnt0 + (lb0_wr ? 1 : 0) - (lb0_rd ? 1 : 0);
      cnt1 <= cnt1 + (lb1_wr ? 1 : 0) - (lb1_rd ? 1 : 0);
      if ((lb0_rd && lb0_wr) || (lb1_rd && lb1_wr)) conflict <= 1'b1;
      if ((lb0_wr && !lb0_rd && cnt0 == W) || (lb1_wr && !lb1_rd && cnt1 == W)) overflow <= 1'b1;
    end
  end

  // Values observed during the last pixel transaction.
  logic       lastRd0, lastRd1, lastWr0, lastWr1, lastDin0, lastDin1;
  logic       lastWv, lastFd, lastLbRst, lastReady, lastErr;
  logic [8:0] lastWin;
  logic       holdValid;

  // Pixel patterns used by the frame tests.
  function automatic logic pixVal(input int sel, input int x, input int y);
    case (sel)
      0:       return 1'b1;
      1:       return 1'((x + y) & 1);
      default: return 1'(((x * 3 + y * 5 + x * y) % 7) < 3);
    endcase
  endfunction

  // Reference window: bit (2-j)*3+(2-i) holds pixel (x-2+i, y-2+j).
  function automatic logic [8:0] expWin(input int sel, input int x, input int y);
    logic [8:0] w;
    w = '0;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++)
        w[(2 - j) * 3 + (2 - i)] = pixVal(sel, x - 2 + i, y - 2 + j);
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one pixel, starting from a negedge. It records the strobes seen
  // in RD and WR and the outputs in cycle 4.
  task automatic applyStimulus(input logic p);
    int waitCnt;
    waitCnt = 0;
    while (!pix_ready && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt == 10) checkOutput("readyTimeout", 32'(pix_ready), 32'd1);
    pix_valid = 1'b1;
    pix_in    = p;
    @(negedge clk);
    pix_valid = holdValid;
    lastRd0 = lb0_rd;
    lastRd1 = lb1_rd;
    @(negedge clk);
    @(negedge clk);
    lastWr0  = lb0_wr;
    lastWr1  = lb1_wr;
    lastDin0 = lb0_din;
    lastDin1 = lb1_din;
    @(negedge clk);
    lastWv    = win_valid;
    lastWin   = win;
    lastFd    = frame_done;
    lastLbRst = lb_rst;
    lastReady = pix_ready;
    lastErr   = err;
  endtask

  task automatic doReset();
    holdValid = 1'b0;
    pix_valid = 1'b0;
    force1    = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [8:0] logA [0:W*H-1];
  int         nA, nB, pulses, badWin, fdCnt, lbrCnt, rdRow0;

  initial begin
    rst = 1'b0; pix_valid = 1'b0; pix_in = 1'b0; force1 = 1'b0; holdValid = 1'b0;

    // Reset values are visible while rst is held.
    #2 rst = 1'b1;
    #1;
    checkOutput("rstPixReady", 32'(pix_ready), 32'd1);
    checkOutput("rstWin", 32'(win), 32'd0);
    checkOutput("rstOutputs", {24'd0, win_valid, frame_done, err, lb_rst, lb0_rd, lb1_rd, lb0_wr, lb1_wr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single pixel straight after reset.
    applyStimulus(1'b1);
    checkOutput("singleRd", {30'd0, lastRd0, lastRd1}, 32'd0);
    checkOutput("singleWr1", {30'd0, lastWr1, lastDin1}, 32'd3);
    checkOutput("singleWr0", 32'(lastWr0), 32'd0);
    checkOutput("singleReady", 32'(lastReady), 32'd1);
    checkOutput("singleWv", 32'(lastWv), 32'd0);

    // Reset in the CAP cycle of pixel (5,3) of an all-ones frame.
    doReset();
    for (int k = 0; k < 3 * W + 5; k++) applyStimulus(1'b1);
    checkOutput("preRstWin", 32'(lastWin), 32'h1FF);
    pix_valid = 1'b1;
    pix_in    = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstWin", 32'(win), 32'd0);
    checkOutput("midRstOutputs", {24'd0, win_valid, frame_done, err, lb_rst, lb0_rd, lb1_rd, lb0_wr, lb1_wr}, 32'd0);
    checkOutput("midRstReady", 32'(pix_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1);
    checkOutput("afterRstRd", {30'd0, lastRd0, lastRd1}, 32'd0);
    checkOutput("afterRstWr0", 32'(lastWr0), 32'd0);

    // All-ones frame.
    doReset();
    pulses = 0; badWin = 0; fdCnt = 0; lbrCnt = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        applyStimulus(1'b1);
        if (lastWv) begin
          pulses++;
          if (lastWin !== 9'h1FF) badWin++;
        end
        if (lastFd) fdCnt++;
        if (lastLbRst) lbrCnt++;
        if (x == W - 1 && y == 0) checkOutput("lb1FullRow0", 32'(cnt1), 32'(W));
        if (x == W - 1 && y == 1) checkOutput("lb0FullRow1", 32'(cnt0), 32'(W));
      end
    end
    checkOutput("onesFdLast", {30'd0, lastFd, lastLbRst}, 32'd3);
    checkOutput("onesWvLast", 32'(lastWv), 32'd1);
    checkOutput("onesPulses", 32'(pulses), 32'd144);
    checkOutput("onesBadWin", 32'(badWin), 32'd0);
    checkOutput("onesFdCount", 32'(fdCnt), 32'd1);
    checkOutput("onesLbRstCount", 32'(lbrCnt), 32'd1);
    checkOutput("onesConflictOverflow", {30'd0, conflict, overflow}, 32'd0);
    @(negedge clk);
    checkOutput("flushedBuffers", 32'(cnt0 + cnt1), 32'd0);
    checkOutput("flushNoFd", 32'(frame_done), 32'd0);

    // Checkerboard pattern (x+y)&1.
    doReset();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        applyStimulus(pixVal(1, x, y));
        checkOutput("chkWv", 32'(lastWv), 32'(x >= 2 && y >= 2));
        checkOutput("chkFd", 32'(lastFd), 32'(x == W - 1 && y == H - 1));
        if (x >= 2 && y >= 2) checkOutput("chkWin", 32'(lastWin), 32'(expWin(1, x, y)));
        if (x == 2 && y == 2) checkOutput("win(2,2)", 32'(lastWin), 32'h0AA);
        if (x == 3 && y == 2) checkOutput("win(3,2)", 32'(lastWin), 32'h155);
        if (x == 4 && y == 1) checkOutput("winHeld", 32'(lastWin), 32'd0);
      end
    end

    // Underflow on lb1 during pixel (0,1).
    doReset();
    for (int k = 0; k < W; k++) applyStimulus(1'b1);
    checkOutput("noErrRow0", 32'(err), 32'd0);
    force1 = 1'b1;
    applyStimulus(1'b1);
    force1 = 1'b0;
    checkOutput("uflowRd1", 32'(lastRd1), 32'd0);
    checkOutput("uflowWr0", {30'd0, lastWr0, lastDin0}, 32'd2);
    checkOutput("uflowErr", 32'(lastErr), 32'd1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0);
    checkOutput("uflowErrSticky", 32'(err), 32'd1);
    doReset();
    checkOutput("uflowErrCleared", 32'(err), 32'd0);

    // Back-to-back frames with pix_valid held high.
    doReset();
    holdValid = 1'b1;
    nA = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        applyStimulus(pixVal(2, x, y));
        if (lastWv) begin
          logA[nA] = lastWin;
          nA++;
          checkOutput("b2bModelWin", 32'(lastWin), 32'(expWin(2, x, y)));
        end
      end
    end
    checkOutput("b2bFd1", {30'd0, lastFd, lastLbRst}, 32'd3);
    nB = 0; rdRow0 = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        applyStimulus(pixVal(2, x, y));
        if (y == 0 && (lastRd0 || lastRd1)) rdRow0++;
        if (lastWv) begin
          if (nB < nA) checkOutput("b2bSameWin", 32'(lastWin), 32'(logA[nB]));
          nB++;
        end
      end
    end
    holdValid = 1'b0;
    pix_valid = 1'b0;
    checkOutput("b2bRdRow0", 32'(rdRow0), 32'd0);
    checkOutput("b2bCountA", 32'(nA), 32'd144);
    checkOutput("b2bCountB", 32'(nB), 32'd144);
    checkOutput("b2bFd2", 32'(lastFd), 32'd1);
    checkOutput("b2bConflictOverflow", {30'd0, conflict, overflow}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL globalTimeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
